sqrt_batch_controller: RTL and testbench
========================================

# sqrt_batch_controller

Parametrised successor to the single-shot sequential controller for the `psdsqrt` core. It accepts square-root requests through a `DEPTH`-entry operand FIFO and sequences them through one `psdsqrt` instance. For each request it issues the core's `start`/`stop` pulses with a programmable compute latency, then returns each result with a one-cycle valid strobe. It adds queuing, back-pressure, abort and a completion counter, none of which the single-run controller provides.

## Interface
- `NBITSIN`, 16: operand width; must be even. The result width is `NBITSIN/2`.
- `DEPTH`, 4: operand FIFO entries; must be a power of two, at least 2.
- `LATENCY`, `NBITSIN/2`: number of cycles from `core_start` high to `core_stop` high; minimum 1.
- `clock`  in  1  master clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous, active-low; sampled only at the rising edge of `clock`.
- `run`  in  1  request strobe; `xin` is pushed whenever `run`=1 at a rising edge.
- `xin`  in  NBITSIN  operand to push.
- `abort`  in  1  synchronous flush of the FIFO and sequence; active high.
- `ready`  out  1  FIFO not full; combinational (`count != DEPTH`).
- `core_start`  out  1  one-cycle start pulse to `psdsqrt`.
- `core_stop`  out  1  one-cycle stop pulse to `psdsqrt`.
- `core_xin`  out  NBITSIN  registered operand to `psdsqrt`.
- `core_sqrt`  in  NBITSIN/2  result from `psdsqrt`.
- `sqrt_out`  out  NBITSIN/2  registered result; holds its value until the next capture.
- `out_valid`  out  1  one-cycle strobe; `sqrt_out` is new in this cycle.
- `busy`  out  1  high when state != IDLE or the FIFO is not empty.
- `count`  out  clog2(DEPTH+1)  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a push was dropped because the FIFO was full.
- `done_count`  out  16  number of completed results; wraps from 65535 to 0.

## Operation
- State machine with states IDLE, START, WAIT, STOP, CAPTURE.
- IDLE: stays in IDLE while the FIFO is empty; moves to START when `count`>0.
- START (1 cycle):
  - `core_start`=1.
  - `core_xin` is loaded from the FIFO head and that entry is popped.
  - The wait counter is loaded with `LATENCY-1`.
- WAIT: decrements the wait counter each cycle; moves to STOP when the counter reaches 0. If `LATENCY`=1, WAIT is skipped.
- STOP (1 cycle): `core_stop`=1.
- CAPTURE (1 cycle):
  - `sqrt_out` is loaded from `core_sqrt` and `out_valid`=1.
  - `done_count` increments.
  - Next state is START if `count`>0, otherwise IDLE.
- `core_xin` is held stable from START through CAPTURE.
- FIFO behaviour:
  - A push while full is dropped and sets `overflow`; `count` is unchanged.
  - A simultaneous push and pop leaves `count` unchanged and is legal even when full: the pop frees the slot first.
  - Read and write pointers wrap modulo `DEPTH`.
- Abort: `abort`=1 at an edge resets state to IDLE, `count` to 0 and the pointers to 0, and clears `overflow`.
  - No `core_stop` is issued for an aborted operation.
  - `sqrt_out` and `done_count` are preserved.
  - A `run` in the same cycle as `abort` is dropped.
- Reset (`reset`=0 at an edge) takes priority over all inputs. Reset values after that edge:
  - state IDLE; `count`=0; `ready`=1; `busy`=0.
  - `core_start`=0, `core_stop`=0, `core_xin`=0.
  - `sqrt_out`=0, `out_valid`=0, `overflow`=0, `done_count`=0.
- Reset in the middle of an operation abandons it the same way as abort, with no `core_stop`.

## Timing
- Edge k samples `run`=1 with the controller idle and the FIFO empty:
  - `count`=1 after edge k.
  - START (`core_start`=1) after edge k+1.
  - `core_stop`=1 after edge k+1+`LATENCY`.
  - `out_valid`=1 after edge k+2+`LATENCY`.
- Back-to-back queued requests: `core_start` pulses are `LATENCY`+2 cycles apart, because CAPTURE goes directly to START.
- `out_valid` is never high for two consecutive cycles.
- `core_start` and `core_stop` are never high in the same cycle.

## Test plan
- Single requests, one at a time, with NBITSIN=16 and LATENCY=8:
  - `xin`=100, 12, 13, 1057, 4300 give `sqrt_out`=10, 3, 3, 32, 65.
  - Each `out_valid` appears exactly 10 cycles after the `run` edge.
- Burst of 4 `run` pulses on consecutive cycles (0, 1, 65535, 16384):
  - Results appear in order: 0, 1, 255, 128.
  - `out_valid` strobes are 10 cycles apart; `done_count`=4; `overflow`=0.
- Overflow: 6 consecutive pushes with DEPTH=4.
  - `ready` goes low after the 4th-entry condition (the FIFO reaching full).
  - The 6th push is dropped and `overflow`=1.
  - Exactly 5 results are produced: the first push starts immediately and frees a slot.
- Abort in WAIT with 2 requests queued:
  - No `core_stop` and no `out_valid` follow.
  - `count`=0, `busy`=0 next cycle; `done_count` is unchanged.
- `reset`=0 asserted mid-WAIT for 2 cycles: all outputs take their reset values; a subsequent request for 144 yields 12.
- LATENCY=1 variant: `core_stop` directly follows `core_start`; 49 yields 7.

Source files
------------

// File: rtl/sqrt_batch_controller.sv
// sqrt_batch_controller: queues square-root operands in a small FIFO and
// sequences them one at a time through a single psdsqrt core, issuing the
// core's start/stop pulses with a fixed compute latency and returning each
// result with a one-cycle valid strobe.
module sqrt_batch_controller #(
    parameter int unsigned NBITSIN = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = NBITSIN / 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         run,
    input  logic [NBITSIN-1:0]           xin,
    input  logic                         abort,
    output logic                         ready,
    output logic                         core_start,
    output logic                         core_stop,
    output logic [NBITSIN-1:0]           core_xin,
    input  logic [NBITSIN/2-1:0]         core_sqrt,
    output logic [NBITSIN/2-1:0]         sqrt_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [15:0]                  done_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STOP,
        CAPTURE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WW-1:0]     wait_cnt;
    logic [WW-1:0]     wait_next;
    logic [NBITSIN-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign ready = (count != CW'(DEPTH));

    // State and wait-counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Next state, FIFO push/pop decisions and next occupancy.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        pop        = 1'b0;
        full       = (count == CW'(DEPTH));

        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                wait_next  = WW'(LATENCY - 1);
                state_next = (LATENCY == 1) ? STOP : WAIT;
            end
            WAIT: begin
                wait_next = wait_cnt - WW'(1);
                if (wait_cnt <= WW'(1)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                if (count != '0) begin
                    state_next = START;
                    pop        = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot, so a push to a full FIFO is legal then.
        push = run && (!full || pop);
        drop = run && full && !pop;

        if (abort) begin
            state_next = IDLE;
            pop        = 1'b0;
            push       = 1'b0;
            drop       = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        if (abort) begin
            count_next = '0;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= xin;
        end
    end

    // FIFO pointers, occupancy, registered core handshake and result outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            core_start <= 1'b0;
            core_stop  <= 1'b0;
            core_xin   <= '0;
            sqrt_out   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            done_count <= '0;
        end else begin
            count      <= count_next;
            core_start <= (state_next == START);
            core_stop  <= (state_next == STOP);
            out_valid  <= (state_next == CAPTURE);
            busy       <= (state_next != IDLE) || (count_next != '0);

            if (abort) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + AW'(1);
                    core_xin <= mem[rd_ptr];
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end

            if (state_next == CAPTURE) begin
                sqrt_out   <= core_sqrt;
                done_count <= done_count + 16'(1);
            end
        end
    end

endmodule

// File: tb/tb_sqrt_batch_controller.sv
// Scoreboard bench for sqrt_batch_controller: directed requests push their
// hand-computed result and expected strobe cycle into a queue; a monitor pops
// and compares whenever out_valid is seen.
module tb_sqrt_batch_controller;

    localparam int unsigned NB = 16;
    localparam int unsigned NO = NB / 2;
    localparam int unsigned DP = 4;
    localparam int unsigned CW = $clog2(DP + 1);

    typedef struct {
        int unsigned val;
        int          cyc;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          run;
    logic [NB-1:0] xin;
    logic          abort;
    logic          ready;
    logic          core_start;
    logic          core_stop;
    logic [NB-1:0] core_xin;
    logic [NO-1:0] core_sqrt;
    logic [NO-1:0] sqrt_out;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   done_count;

    logic          run1;
    logic [NB-1:0] xin1;
    logic          abort1;
    logic          ready1;
    logic          core_start1;
    logic          core_stop1;
    logic [NB-1:0] core_xin1;
    logic [NO-1:0] core_sqrt1;
    logic [NO-1:0] sqrt_out1;
    logic          out_valid1;
    logic          busy1;
    logic [CW-1:0] count1;
    logic          overflow1;
    logic [15:0]   done_count1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stop_pulses = 0;
    exp_t exp_q[$];
    exp_t e;
    logic prev_valid = 1'b0;
    logic [NB-1:0] op0 = '0;
    logic [NB-1:0] op1 = '0;

    sqrt_batch_controller #(.NBITSIN(NB), .DEPTH(DP), .LATENCY(8)) u0 (
        .clock(clock), .reset(reset), .run(run), .xin(xin), .abort(abort),
        .ready(ready), .core_start(core_start), .core_stop(core_stop),
        .core_xin(core_xin), .core_sqrt(core_sqrt), .sqrt_out(sqrt_out),
        .out_valid(out_valid), .busy(busy), .count(count),
        .overflow(overflow), .done_count(done_count)
    );

    sqrt_batch_controller #(.NBITSIN(NB), .DEPTH(DP), .LATENCY(1)) u1 (
        .clock(clock), .reset(reset), .run(run1), .xin(xin1), .abort(abort1),
        .ready(ready1), .core_start(core_start1), .core_stop(core_stop1),
        .core_xin(core_xin1), .core_sqrt(core_sqrt1), .sqrt_out(sqrt_out1),
        .out_valid(out_valid1), .busy(busy1), .count(count1),
        .overflow(overflow1), .done_count(done_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [NO-1:0] isqrt(input logic [NB-1:0] x);
        logic [NO-1:0] r;
        r = '0;
        for (int i = 0; i < (1 << NO); i++) begin
            if (i * i <= int'(x)) r = NO'(i);
        end
        return r;
    endfunction

    // Core model: latches the operand on start, drives its result only during stop.
    assign core_sqrt  = core_stop  ? isqrt(op0) : 8'hA5;
    assign core_sqrt1 = core_stop1 ? isqrt(op1) : 8'hA5;

    always @(negedge clock) begin
        if (core_start)  op0 <= core_xin;
        if (core_start1) op1 <= core_xin1;
        if (core_stop)   stop_pulses <= stop_pulses + 1;
        if (core_stop) begin
            checks = checks + 1;
            if (core_xin != op0) begin
                errors = errors + 1;
                $display("FAIL operand_stable core_xin=%0d required=%0d", core_xin, op0);
            end
        end
    end

    // Monitor: compare every presented result against the head of the scoreboard.
    always @(negedge clock) begin
        if (out_valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_result got=%0d at cycle %0d, none expected", sqrt_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (32'(sqrt_out) != e.val || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL result got=%0d@%0d required=%0d@%0d", sqrt_out, cyc, e.val, e.cyc);
                end
            end
            checks = checks + 1;
            if (prev_valid) begin
                errors = errors + 1;
                $display("FAIL valid_back_to_back out_valid high two cycles at %0d", cyc);
            end
        end
        if (core_start || core_stop) begin
            checks = checks + 1;
            if (core_start && core_stop) begin
                errors = errors + 1;
                $display("FAIL start_stop_overlap both high at cycle %0d", cyc);
            end
        end
        prev_valid <= out_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_req(input logic [NB-1:0] x);
        run = 1'b1;
        xin = x;
        tick();
        run = 1'b0;
    endtask

    task automatic expect_res(input int unsigned v, input int at);
        exp_t t;
        t.val = v;
        t.cyc = at;
        exp_q.push_back(t);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},      32'(count), 32'd0);
        check({tag, "_ready"},      32'(ready), 32'd1);
        check({tag, "_busy"},       32'(busy), 32'd0);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_core_stop"},  32'(core_stop), 32'd0);
        check({tag, "_core_xin"},   32'(core_xin), 32'd0);
        check({tag, "_sqrt_out"},   32'(sqrt_out), 32'd0);
        check({tag, "_out_valid"},  32'(out_valid), 32'd0);
        check({tag, "_overflow"},   32'(overflow), 32'd0);
        check({tag, "_done_count"}, 32'(done_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] s_x [5];
        int unsigned   s_r [5];
        logic [NB-1:0] b_x [4];
        int unsigned   b_r [4];
        int k;
        int stops_before;

        s_x = '{16'd100, 16'd12, 16'd13, 16'd1057, 16'd4300};
        s_r = '{10, 3, 3, 32, 65};
        b_x = '{16'd0, 16'd1, 16'd65535, 16'd16384};
        b_r = '{0, 1, 255, 128};

        reset = 1'b0; run = 1'b0; xin = '0; abort = 1'b0;
        run1 = 1'b0; xin1 = '0; abort1 = 1'b0;
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // Burst of four consecutive requests.
        k = cyc + 1;
        for (int i = 0; i < 4; i++) expect_res(b_r[i], k + 10 + 10 * i);
        for (int i = 0; i < 4; i++) push_req(b_x[i]);
        drain(80);
        check("burst_done_count", 32'(done_count), 32'd4);
        check("burst_overflow", 32'(overflow), 32'd0);

        // Single requests, each with an idle controller.
        for (int i = 0; i < 5; i++) begin
            expect_res(s_r[i], cyc + 1 + 10);
            push_req(s_x[i]);
            drain(40);
        end
        check("single_done_count", 32'(done_count), 32'd9);
        check("single_busy_idle", 32'(busy), 32'd0);

        // Six pushes into a four-entry FIFO; the sixth is dropped.
        k = cyc + 1;
        for (int i = 0; i < 5; i++) expect_res(32'(i + 2), k + 10 + 10 * i);
        for (int i = 0; i < 6; i++) begin
            push_req(NB'((i + 2) * (i + 2)));
            if (i == 3) check("ovf_ready_before_full", 32'(ready), 32'd1);
            if (i == 4) begin
                check("ovf_ready_full", 32'(ready), 32'd0);
                check("ovf_count_full", 32'(count), 32'd4);
                check("ovf_flag_before_drop", 32'(overflow), 32'd0);
            end
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count_after_drop", 32'(count), 32'd4);
        drain(80);
        check("ovf_done_count", 32'(done_count), 32'd14);

        // Abort while waiting with two requests queued; a concurrent run is dropped.
        push_req(16'd400);
        push_req(16'd500);
        push_req(16'd600);
        check("abort_pre_count", 32'(count), 32'd2);
        stops_before = stop_pulses;
        abort = 1'b1; run = 1'b1; xin = 16'd700;
        tick();
        abort = 1'b0; run = 1'b0;
        check("abort_count", 32'(count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_done_count", 32'(done_count), 32'd14);
        check("abort_sqrt_out", 32'(sqrt_out), 32'd6);
        repeat (20) tick();
        check("abort_no_stop", 32'(stop_pulses), 32'(stops_before));
        check("abort_count_later", 32'(count), 32'd0);

        // Reset for two edges in the middle of a wait.
        push_req(16'd900);
        repeat (2) tick();
        stops_before = stop_pulses;
        reset = 1'b0;
        repeat (2) tick();
        check_reset_values("midrst");
        reset = 1'b1;
        repeat (12) tick();
        check("midrst_no_stop", 32'(stop_pulses), 32'(stops_before));
        expect_res(12, cyc + 1 + 10);
        push_req(16'd144);
        drain(40);
        check("midrst_done_count", 32'(done_count), 32'd1);

        // Single-cycle latency instance.
        run1 = 1'b1; xin1 = 16'd49;
        tick();
        run1 = 1'b0;
        tick();
        check("lat1_start", 32'(core_start1), 32'd1);
        check("lat1_no_stop_yet", 32'(core_stop1), 32'd0);
        tick();
        check("lat1_start_gone", 32'(core_start1), 32'd0);
        check("lat1_stop", 32'(core_stop1), 32'd1);
        tick();
        check("lat1_valid", 32'(out_valid1), 32'd1);
        check("lat1_result", 32'(sqrt_out1), 32'd7);
        tick();
        check("lat1_valid_gone", 32'(out_valid1), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
